// File: rtl/core_pkg.sv
// Shared types for the RV32 core pipeline control: hazard FSM encodings,
// scoreboard entry layout and the ID/EX bubble constant.
package core_pkg;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_STALL  = 2'd1,
        HZ_FREEZE = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } sb_entry_t;

    localparam int        SB_DEPTH    = 3;
    localparam logic [8:0] CTRL_EX_NOP = 9'd0;
    localparam sb_entry_t SB_EMPTY    = '{v: 1'b0, rd: 5'd0};

    // x0 is hardwired zero, so it can never be a real dependency.
    function automatic logic entry_hit(sb_entry_t e, logic [4:0] r);
        return e.v && (e.rd == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// Destination-register scoreboard for in-flight EX/MEM/WB instructions,
// with per-entry match comparators for both ID source operands.
module hz_scoreboard
    import core_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       shift_i,
    input  sb_entry_t  ins_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    output logic       rs1_hit_o,
    output logic       rs2_hit_o
);

    // A write-before-read register file makes the WB entry already visible.
    localparam logic [SB_DEPTH-1:0] MATCH_MASK =
        WB_BYPASS ? {1'b0, {(SB_DEPTH-1){1'b1}}} : {SB_DEPTH{1'b1}};

    sb_entry_t [SB_DEPTH-1:0] pend_q;
    logic      [SB_DEPTH-1:0] hit1, hit2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= {SB_DEPTH{SB_EMPTY}};
        end else if (shift_i) begin
            pend_q <= {pend_q[SB_DEPTH-2:0], ins_i};
        end
    end

    for (genvar i = 0; i < SB_DEPTH; i++) begin : g_cmp
        assign hit1[i] = entry_hit(pend_q[i], rs1_i) & MATCH_MASK[i];
        assign hit2[i] = entry_hit(pend_q[i], rs2_i) & MATCH_MASK[i];
    end

    assign rs1_hit_o = |hit1;
    assign rs2_hit_o = |hit2;

endmodule

// File: rtl/hazard_ctrl.sv
// RAW interlock and pipeline sequencing for the 5-stage core: classifies each
// cycle as RUN/STALL/FREEZE and decodes PC/IF-ID/ID-EX controls from it.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_jump,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt
);

    hz_state_e        state_q, state_d, cls;
    logic             rs1_hit, rs2_hit, raw;
    sb_entry_t        sb_ins;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    hz_scoreboard #(.WB_BYPASS(WB_BYPASS)) u_sb (
        .clk       (clk),
        .reset_n   (reset_n),
        .shift_i   (cls != HZ_FREEZE),
        .ins_i     (sb_ins),
        .rs1_i     (id_rs1),
        .rs2_i     (id_rs2),
        .rs1_hit_o (rs1_hit),
        .rs2_hit_o (rs2_hit)
    );

    assign raw = id_valid & ((id_rs1_used & rs1_hit) | (id_rs2_used & rs2_hit));

    // Memory wait outranks the interlock so a frozen stall keeps its place.
    always_comb begin
        if (mem_busy)  cls = HZ_FREEZE;
        else if (raw)  cls = HZ_STALL;
        else           cls = HZ_RUN;
        state_d = cls;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= HZ_RUN;
        else          state_q <= state_d;
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        case (cls)
            HZ_RUN: begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = id_jump & id_valid;
            end
            HZ_STALL: idex_bubble = 1'b1;
            default: ;
        endcase
    end

    // A stalled ID issues a bubble, so nothing real enters EX that cycle.
    always_comb begin
        sb_ins = SB_EMPTY;
        if (cls == HZ_RUN) begin
            sb_ins.v  = id_valid & id_reg_write & (id_rd != 5'd0);
            sb_ins.rd = id_rd;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cls == HZ_STALL && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign hz_state  = state_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (no bypass/16-bit counter and
// bypass/2-bit counter) share stimulus and are checked against a queue model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic id_valid = 0, id_rs1_used = 0, id_rs2_used = 0, id_reg_write = 0, id_jump = 0;
    logic mem_busy = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;

    logic pc_en[2], ifid_en[2], ifid_flush[2], idex_bubble[2];
    logic [1:0] hz_st[2];
    logic [15:0] sc0;
    logic [1:0]  sc1;

    always #5 clk = ~clk;

    hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_jump(id_jump), .mem_busy(mem_busy),
        .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .ifid_flush(ifid_flush[0]),
        .idex_bubble(idex_bubble[0]), .hz_state(hz_st[0]), .stall_cnt(sc0));

    hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_jump(id_jump), .mem_busy(mem_busy),
        .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .ifid_flush(ifid_flush[1]),
        .idex_bubble(idex_bubble[1]), .hz_state(hz_st[1]), .stall_cnt(sc1));

    int npass = 0, ntot = 0;

    task automatic chk(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: in-flight destinations by age (0 = youngest), 0 means no write.
    int inflight[2][3] = '{'{0, 0, 0}, '{0, 0, 0}};
    int mcnt[2] = '{0, 0};
    int mst[2]  = '{0, 0};
    int frz_seen[2] = '{0, 0};

    function automatic int visible(input int k);
        return (k == 0) ? 3 : 2;
    endfunction

    function automatic int cmax(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    function automatic bit pending(input int k, input int r);
        if (r == 0) return 1'b0;
        for (int i = 0; i < visible(k); i++)
            if (inflight[k][i] == r) return 1'b1;
        return 1'b0;
    endfunction

    // 0 = run, 1 = stall, 2 = freeze
    function automatic int mcls(input int k);
        if (mem_busy) return 2;
        if (id_valid && ((id_rs1_used && pending(k, int'(id_rs1))) ||
                         (id_rs2_used && pending(k, int'(id_rs2))))) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                inflight[k] <= '{0, 0, 0};
                mcnt[k] <= 0;
                mst[k]  <= 0;
            end else begin
                mst[k] <= mcls(k);
                if (mcls(k) == 1 && mcnt[k] < cmax(k)) mcnt[k] <= mcnt[k] + 1;
                if (mcls(k) != 2) begin
                    inflight[k][2] <= inflight[k][1];
                    inflight[k][1] <= inflight[k][0];
                    inflight[k][0] <= (mcls(k) == 0 && id_valid && id_reg_write) ? int'(id_rd) : 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("pc_en%0d", k),       int'(pc_en[k]),       int'(mcls(k) == 0));
                chk($sformatf("ifid_en%0d", k),     int'(ifid_en[k]),     int'(mcls(k) == 0));
                chk($sformatf("idex_bubble%0d", k), int'(idex_bubble[k]), int'(mcls(k) == 1));
                chk($sformatf("ifid_flush%0d", k),  int'(ifid_flush[k]),
                    int'(mcls(k) == 0 && id_jump && id_valid));
                chk($sformatf("hz_state%0d", k),    int'(hz_st[k]),       mst[k]);
                chk($sformatf("stall_cnt%0d", k),   (k == 0) ? int'(sc0) : int'(sc1), mcnt[k]);
                if (hz_st[k] == 2'd2) frz_seen[k]++;
            end
        end
    end

    typedef struct {
        bit v; int rs1; bit u1; int rs2; bit u2; int rd; bit w; bit j;
    } ins_t;

    function automatic ins_t mk(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit w, bit j);
        ins_t i;
        i.v = v; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2; i.rd = rd; i.w = w; i.j = j;
        return i;
    endfunction

    int cyc = 0, busy_start = -100, busy_len = 0;

    task automatic drive(input ins_t i);
        id_valid = i.v; id_rs1 = i.rs1[4:0]; id_rs1_used = i.u1;
        id_rs2 = i.rs2[4:0]; id_rs2_used = i.u2;
        id_rd = i.rd[4:0]; id_reg_write = i.w; id_jump = i.j;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        mem_busy = (cyc >= busy_start) && (cyc < busy_start + busy_len);
    endtask

    // Hold an instruction in ID until the selected instance's model lets it go.
    task automatic issue(input ins_t i, input int sel);
        int c;
        drive(i);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            c = mcls(sel);
            tick();
            if (c == 0) return;
        end
        chk("issue_timeout", 1, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        busy_start = -100; busy_len = 0; mem_busy = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_pc_en",    int'(pc_en[k]),       1);
            chk("rst_bubble",   int'(idex_bubble[k]), 0);
            chk("rst_flush",    int'(ifid_flush[k]),  0);
            chk("rst_hz_state", int'(hz_st[k]),       0);
        end
        chk("rst_cnt0", int'(sc0), 0);
        chk("rst_cnt1", int'(sc1), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    ins_t nop, add5, add6dep, addx0, add7x0, add6ind, add7both, add7dep6, beq, beqdep;

    initial begin
        nop      = mk(0, 0, 0, 0, 0, 0, 0, 0);
        add5     = mk(1, 1, 1, 2, 1, 5, 1, 0);
        add6dep  = mk(1, 5, 1, 1, 1, 6, 1, 0);
        addx0    = mk(1, 0, 1, 0, 0, 0, 1, 0);
        add7x0   = mk(1, 0, 1, 0, 1, 7, 1, 0);
        add6ind  = mk(1, 1, 1, 2, 1, 6, 1, 0);
        add7both = mk(1, 5, 1, 6, 1, 7, 1, 0);
        add7dep6 = mk(1, 6, 1, 1, 1, 7, 1, 0);
        beq      = mk(1, 1, 1, 2, 1, 0, 0, 1);
        beqdep   = mk(1, 5, 1, 2, 1, 0, 0, 1);

        do_reset();
        // back-to-back dependency, paced by the non-bypass instance
        issue(add5, 0); issue(add6dep, 0); issue(nop, 0); issue(nop, 0);
        chk("dep1_cnt0", int'(sc0), 3);
        chk("dep1_cnt1", int'(sc1), 2);

        do_reset();
        // same sequence paced by the bypass instance
        issue(add5, 1); issue(add6dep, 1); issue(nop, 1); issue(nop, 1);
        chk("dep1b_cnt1", int'(sc1), 2);
        chk("dep1b_cnt0", int'(sc0), 3);

        do_reset();
        issue(addx0, 0); issue(add7x0, 0); issue(nop, 0);
        chk("x0_cnt0", int'(sc0), 0);
        chk("x0_cnt1", int'(sc1), 0);

        do_reset();
        drive(beq);
        @(negedge clk);
        chk("jmp_flush", int'(ifid_flush[0]), 1);
        chk("jmp_pc_en", int'(pc_en[0]), 1);
        tick();
        drive(nop);
        @(negedge clk);
        chk("jmp_flush_off", int'(ifid_flush[0]), 0);
        tick();

        do_reset();
        // memory wait in the middle of an interlock
        frz_seen = '{0, 0};
        issue(add5, 0);
        busy_start = cyc + 1; busy_len = 4;
        issue(add6dep, 0); issue(nop, 0); issue(nop, 0);
        chk("frz_cnt0", int'(sc0), 3);
        chk("frz_cnt1", int'(sc1), 2);
        chk("frz_seen0", frz_seen[0], 4);
        chk("frz_seen1", frz_seen[1], 4);

        do_reset();
        // branch depending on a result: flush waits for the first run cycle
        issue(add5, 0); issue(beqdep, 0); issue(nop, 0);
        chk("jdep_cnt0", int'(sc0), 3);

        do_reset();
        // two sources hit different entries; youngest one governs
        issue(add5, 0); issue(add6ind, 0); issue(add7both, 0); issue(nop, 0); issue(nop, 0);
        chk("both_cnt0", int'(sc0), 3);
        chk("both_cnt1", int'(sc1), 2);

        do_reset();
        // chained dependencies push the 2-bit counter into saturation
        issue(add5, 1); issue(add6dep, 1); issue(add7dep6, 1); issue(nop, 1); issue(nop, 1);
        chk("sat_cnt1", int'(sc1), 3);

        do_reset();
        // reset dropped in the middle of an interlock
        issue(add5, 0);
        drive(add6dep);
        tick();
        chk("mid_cnt0", int'(sc0), 1);
        do_reset();
        drive(add6dep);
        @(negedge clk);
        chk("post_rst_pc_en", int'(pc_en[0]), 1);
        chk("post_rst_state", int'(hz_st[0]), 0);
        chk("post_rst_cnt", int'(sc0), 0);
        tick();
        drive(nop);
        tick(); tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

RAW interlock and pipeline sequencing controller for the 5-stage RV32 core. Sits beside the ID stage. Tracks destination registers of in-flight instructions (EX/MEM/WB) in a scoreboard. Stalls PC and IF/ID while an ID source operand is pending, since the core has no forwarding and branch compare runs in ID. Also squashes the IF/ID slot on a taken jump/branch, and freezes the whole pipe while data memory is busy.

## Interface
Parameters:
- WB_BYPASS, 0, 1 = register file is write-before-read, so the WB entry is excluded from matching.
- CNT_W, 16, width of stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5 each  ID source register numbers.
- id_rs1_used, id_rs2_used  in  1 each  source actually read (from ID decode).
- id_rd  in  5  ID destination register.
- id_reg_write  in  1  ID instruction writes rd (ctrl bit RegWrite).
- id_jump  in  1  ID resolves a taken jump/branch (control_j).
- mem_busy  in  1  data memory wait; freezes the whole pipe.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  load NOP into IF/ID this edge.
- idex_bubble  out  1  load all-zero ctrl_ex into ID/EX this edge.
- hz_state  out  2  registered FSM state.
- stall_cnt  out  CNT_W  saturating count of interlock cycles.

## Operation
- Scoreboard: 3 entries, each {v, rd[4:0]}. pend[0]=EX, pend[1]=MEM, pend[2]=WB.
- Match: match(r) = r!=0 & any pend[i].v & pend[i].rd==r, for i in 0..2. pend[2] is excluded when WB_BYPASS=1.
- raw = id_valid & ((id_rs1_used & match(id_rs1)) | (id_rs2_used & match(id_rs2))).
- Cycle class, in priority order:
  - FREEZE if mem_busy.
  - else STALL if raw.
  - else RUN.
- FREEZE: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0; scoreboard holds.
- STALL: pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0. id_jump is ignored because operands are stale. Scoreboard shifts with pend[0] <= {0,0}.
- RUN: pc_en=1, ifid_en=1, idex_bubble=0, ifid_flush=id_jump&id_valid. Scoreboard shifts with pend[0] <= {id_valid&id_reg_write&(id_rd!=0), id_rd}.
- Shift rule: pend[2]<=pend[1], pend[1]<=pend[0], then pend[0] is loaded as above. The entry leaving pend[2] is retired.
- FSM hz_state: RUN=2'd0, STALL=2'd1, FREEZE=2'd2. The register takes the current cycle class at each edge; 2'd3 is unused and recovers to RUN.
- stall_cnt increments on every edge whose class is STALL and saturates at all-ones. FREEZE cycles are not counted.
- Outputs pc_en, ifid_en, ifid_flush and idex_bubble are combinational from inputs and scoreboard.

## Timing
- Reset (async assert, sync-safe release): all pend[i].v=0, hz_state=RUN, stall_cnt=0.
  - With mem_busy=0, outputs under reset are pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
  - An interlock in progress is abandoned on reset.
- Interlock latency: a dependent instruction directly behind its producer stalls 3 cycles (2 when WB_BYPASS=1). At distance 2 it stalls 2 cycles (1); at distance 3 it stalls 1 cycle (0).
- Freeze during a stall: the stall remains in effect after mem_busy drops. The scoreboard did not advance, so the remaining stall count is unchanged.
- id_jump during a stall: the flush is issued in the first RUN cycle, with id_jump still asserted by ID.
- x0: never matches and is never entered valid.
- Both sources hitting different entries: the stall lasts until the youngest matching entry retires.

## Structure
- core_pkg holds:
  - state encodings HZ_RUN/HZ_STALL/HZ_FREEZE.
  - scoreboard entry typedef {v, rd}.
  - the NOP ctrl_ex constant 9'd0.
- One sub-module, hz_scoreboard, holds the shift register and the match comparators. hazard_ctrl holds the classifier, FSM, counter and output decode.

## Test plan
- Pipeline `add x5,..` followed immediately by `add x6,x5,x1` (WB_BYPASS=0) -> STALL for 3 cycles: idex_bubble=1, pc_en=0, stall_cnt=3. RUN resumes on the 4th cycle.
- Same sequence with WB_BYPASS=1 -> 2 stall cycles, stall_cnt=2.
- `addi x0,x0,1` then `add x7,x0,x0` -> no stall; pend[0].v=0.
- BEQ in ID with id_jump=1 and no RAW -> ifid_flush=1 for exactly 1 cycle; pc_en=1.
- mem_busy=1 for 4 cycles in the middle of a 3-cycle interlock -> hz_state=FREEZE for 4 cycles, then the remaining stall cycles complete. stall_cnt ends at 3.
- reset_n pulsed low mid-interlock -> next cycle hz_state=RUN, stall_cnt=0, scoreboard empty, pc_en=1.
